// File: rtl/spi_rx_frame_if.sv
// Bundle of SPI pins and the received-word handshake for spi_rx_frame.
// slave: the receiver side; master: whoever drives SPI and consumes words.
interface spi_rx_frame_if #(
  parameter int NUM_BITS = 12
);
  logic                sck;
  logic                mosi;
  logic                ss_n;
  logic                rx_ready;
  logic                overrun_clr;
  logic [NUM_BITS-1:0] rx_data;
  logic                rx_valid;
  logic                busy;
  logic                overrun;

  modport slave (
    input  sck, mosi, ss_n, rx_ready, overrun_clr,
    output rx_data, rx_valid, busy, overrun
  );

  modport master (
    output sck, mosi, ss_n, rx_ready, overrun_clr,
    input  rx_data, rx_valid, busy, overrun
  );
endinterface

// File: rtl/spi_rx_frame.sv
// SPI mode-0 frame receiver with one-word output buffer.
// Optional macro SPI_RX_OVERRUN_EN: drop words arriving while the buffer is full and flag overrun.
//
// state | meaning
// IDLE  | waiting for ss_n low
// RECV  | shifting in bits on synchronized sck rising edges
// WAIT  | frame complete, ignoring sck until ss_n returns high
module spi_rx_frame #(
  parameter int NUM_BITS = 12
) (
  input  logic          clk,
  input  logic          n_rst,
  spi_rx_frame_if.slave bus
);

  localparam int CW = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    WAIT = 2'd2
  } state_t;

  logic                sck_s1_q, sck_s2_q, sck_prev_q;
  logic                mosi_s1_q, mosi_s2_q;
  logic                ss_s1_q, ss_s2_q;
  logic [1:0]          prime_q;
  logic                armed_q;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_BITS-1:0] shift_q;
  logic [NUM_BITS-1:0] shift_d;
  logic                busy_q;

  logic [NUM_BITS-1:0] rx_data_q;
  logic                rx_valid_q;
  logic                overrun_q;

  logic                sck_pulse;
  logic                word_done;
  logic                load_ok;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      prime_q    <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      sck_s1_q   <= bus.sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      mosi_s1_q  <= bus.mosi;
      mosi_s2_q  <= mosi_s1_q;
      ss_s1_q    <= bus.ss_n;
      ss_s2_q    <= ss_s1_q;
      prime_q    <= {prime_q[0], 1'b1};
      // Only a real ss_n high (not the synchronizer reset value) arms a new frame,
      // so a frame interrupted by reset is never picked up halfway through.
      if (prime_q[1] && ss_s2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sck_pulse = sck_s2_q & ~sck_prev_q;
  assign shift_d   = {shift_q[NUM_BITS-2:0], mosi_s2_q};
  assign word_done = (state_q == RECV) && !ss_s2_q && sck_pulse &&
                     (cnt_q == CW'(NUM_BITS - 1));
  assign load_ok   = !rx_valid_q || bus.rx_ready;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ss_s2_q && armed_q) begin
            state_q <= RECV;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RECV: begin
          if (ss_s2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (sck_pulse) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(NUM_BITS - 1)) begin
              state_q <= WAIT;
              busy_q  <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (ss_s2_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (word_done && load_ok) begin
      rx_data_q  <= shift_d;
      rx_valid_q <= 1'b1;
    end else if (word_done) begin
`ifndef SPI_RX_OVERRUN_EN
      rx_data_q  <= shift_d;
`endif
      rx_valid_q <= 1'b1;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

`ifdef SPI_RX_OVERRUN_EN
  // Set takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overrun_q <= 1'b0;
    end else if (word_done && !load_ok) begin
      overrun_q <= 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end
`else
  logic unused_overrun_clr;
  assign unused_overrun_clr = bus.overrun_clr;
  assign overrun_q          = 1'b0;
`endif

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_spi_rx_frame.sv
// Self-checking bench for spi_rx_frame: vector table of frames plus corner-case sequences,
// with a scoreboard queue checked at every rx_valid/rx_ready handshake.
module tb_spi_rx_frame;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  spi_rx_frame_if #(.NUM_BITS(12)) bus ();

  spi_rx_frame #(.NUM_BITS(12)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] data;
    int          extra;
  } vec_t;

  vec_t        vecs [5];
  logic [11:0] exp_q [$];
  logic [11:0] exp_w;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // mode 0: plain; 1: latency / single-cycle checks on last bit; 2: handshake on completion edge
  task automatic frame(input logic [11:0] d, input int nbits, input int extra,
                       input int mode, input bit end_ss);
    bus.ss_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = d[11-i];
      tick(1);
      bus.sck = 1'b1;
      if (i == 11 && mode != 0) begin
        tick(2);
        if (mode == 1) chk("lat_early", bus.rx_valid, 0);
        else           bus.rx_ready = 1'b1;
        tick(1);
        if (mode == 2) bus.rx_ready = 1'b0;
        chk("lat_valid", bus.rx_valid, 1);
        chk("lat_data", bus.rx_data, d);
        chk("busy_done", bus.busy, 0);
        if (mode == 2) chk("hs_overrun", bus.overrun, 0);
        tick(1);
        if (mode == 1) chk("one_cycle", bus.rx_valid, 0);
      end else begin
        tick(4);
      end
      bus.sck = 1'b0;
      tick(4);
    end
    for (int j = 0; j < extra; j++) begin
      bus.mosi = 1'b0;
      tick(1);
      bus.sck = 1'b1;
      tick(4);
      bus.sck = 1'b0;
      tick(4);
    end
    if (end_ss) begin
      bus.ss_n = 1'b1;
      tick(4);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick(1);
    chk("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (n_rst && bus.rx_valid && bus.rx_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL word_unexpected: got 0x%0h required none", bus.rx_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.rx_data !== exp_w) begin
          n_err++;
          $display("FAIL word_data: got 0x%0h required 0x%0h", bus.rx_data, exp_w);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{12'hA5C, 0};
    vecs[1] = '{12'h000, 0};
    vecs[2] = '{12'hFFF, 2};
    vecs[3] = '{12'h5A3, 0};
    vecs[4] = '{12'h801, 1};

    bus.sck = 1'b0;
    bus.mosi = 1'b0;
    bus.ss_n = 1'b1;
    bus.rx_ready = 1'b0;
    bus.overrun_clr = 1'b0;
    n_rst = 1'b0;
    tick(3);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    n_rst = 1'b1;
    tick(2);

    bus.rx_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].data);
      frame(vecs[v].data, 12, vecs[v].extra, 1, 1'b1);
      drain();
    end

    // Aborted frame produces nothing; the following full frame is received.
    frame(12'hABC, 7, 0, 0, 1'b1);
    chk("abort_valid", bus.rx_valid, 0);
    chk("abort_busy", bus.busy, 0);
    exp_q.push_back(12'h123);
    frame(12'h123, 12, 0, 1, 1'b1);
    drain();

    // Second word while the first is still unconsumed.
    bus.rx_ready = 1'b0;
    frame(12'h111, 12, 0, 0, 1'b1);
    chk("ovr_first_valid", bus.rx_valid, 1);
    chk("ovr_first_data", bus.rx_data, 12'h111);
    frame(12'h222, 12, 0, 0, 1'b1);
    chk("ovr_valid", bus.rx_valid, 1);
`ifdef SPI_RX_OVERRUN_EN
    chk("ovr_data", bus.rx_data, 12'h111);
    chk("ovr_flag", bus.overrun, 1);
    bus.overrun_clr = 1'b1;
    tick(1);
    bus.overrun_clr = 1'b0;
    chk("ovr_clr", bus.overrun, 0);
    exp_q.push_back(12'h111);
`else
    chk("ovr_data", bus.rx_data, 12'h222);
    chk("ovr_flag", bus.overrun, 0);
    bus.overrun_clr = 1'b1;
    tick(1);
    bus.overrun_clr = 1'b0;
    chk("ovr_clr", bus.overrun, 0);
    exp_q.push_back(12'h222);
`endif
    bus.rx_ready = 1'b1;
    drain();

    // New word lands on the same edge the pending word is handshaked.
    bus.rx_ready = 1'b0;
    frame(12'h111, 12, 0, 0, 1'b1);
    exp_q.push_back(12'h111);
    frame(12'h3C3, 12, 0, 2, 1'b1);
    chk("hs_queue", exp_q.size(), 0);
    exp_q.push_back(12'h3C3);
    bus.rx_ready = 1'b1;
    drain();

    // Reset in the middle of a frame with a full buffer.
    bus.rx_ready = 1'b0;
    frame(12'h0AA, 12, 0, 0, 1'b1);
    frame(12'h055, 12, 0, 0, 1'b1);
    frame(12'h7FF, 5, 0, 0, 1'b0);
    chk("pre_rst_busy", bus.busy, 1);
    n_rst = 1'b0;
    tick(1);
    chk("mid_rst_data", bus.rx_data, 0);
    chk("mid_rst_valid", bus.rx_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_overrun", bus.overrun, 0);
    n_rst = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.mosi = 1'b1;
      tick(1);
      bus.sck = 1'b1;
      tick(4);
      bus.sck = 1'b0;
      tick(4);
    end
    chk("post_rst_valid", bus.rx_valid, 0);
    chk("post_rst_busy", bus.busy, 0);
    bus.ss_n = 1'b1;
    tick(4);
    bus.rx_ready = 1'b1;
    exp_q.push_back(12'h0F0);
    frame(12'h0F0, 12, 0, 1, 1'b1);
    drain();

    tick(5);
    chk("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
